// File: rtl/regfile_wb_ctl.sv
// Writeback/scoreboard stage ahead of the register file: merges ALU results and
// in-order load returns into one registered write port, tracks pending loads, stalls issue.
module regfile_wb_ctl #(
    parameter int LDQ_DEPTH = 4
) (
    input  logic        SYSCLK,
    input  logic        RESET_D1_R,
    input  logic        ISSUE_VALID_S,
    input  logic [4:0]  RSA_S,
    input  logic [4:0]  RSB_S,
    input  logic [4:0]  RD_S,
    output logic        ISSUE_STALL_S,
    output logic [9:0]  READA_S,
    output logic [9:0]  READB_S,
    input  logic        ALU_VALID_E,
    input  logic [4:0]  ALU_RD_E,
    input  logic [31:0] ALU_DATA_E,
    output logic        ALU_READY_E,
    input  logic        LD_ISSUE_E,
    input  logic [4:0]  LD_RD_E,
    output logic        LD_FULL_E,
    input  logic        LD_RET_VALID_M,
    input  logic [31:0] LD_RET_DATA_M,
    output logic [31:1] WRITEC_W_R,
    output logic [31:0] REGC_W_R
);

    localparam int PW = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
    localparam int CW = $clog2(LDQ_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(LDQ_DEPTH);

    // Banked read select: bank number on top, one-hot of the low three bits below.
    function automatic logic [9:0] read_sel(input logic [4:0] r);
        return {r[4:3], 8'b1 << r[2:0]};
    endfunction

    logic [31:1]   pend, pend_n;
    logic [4:0]    tag_mem [LDQ_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          hold_full;
    logic [4:0]    hold_rd;
    logic [31:0]   hold_data;
    logic          wb_ld_q;
    logic [4:0]    wb_rd_q;

    logic          push, pop, alu_accept, clr_pend_hit, wb_clr;
    logic          wr_valid, hold_load, hold_clear;
    logic [4:0]    wr_rd;
    logic [31:0]   wr_data;
    logic          wr_is_ld;
    logic [31:1]   wr_dec;
    logic [31:0]   pend_vec;

    assign READA_S     = read_sel(RSA_S);
    assign READB_S     = read_sel(RSB_S);
    assign LD_FULL_E   = (count == DEPTH_C);
    assign ALU_READY_E = ~hold_full;

    assign push       = LD_ISSUE_E & ~LD_FULL_E;
    assign pop        = LD_RET_VALID_M & (count != '0);
    assign alu_accept = ALU_VALID_E & ~hold_full;

    // The load written last cycle is still marked pending until the end of this cycle.
    assign wb_clr       = wb_ld_q & (wb_rd_q != 5'd0);
    assign clr_pend_hit = wb_clr & ((RSA_S == wb_rd_q) | (RSB_S == wb_rd_q) | (RD_S == wb_rd_q));
    assign pend_vec     = {pend, 1'b0};
    assign ISSUE_STALL_S = ISSUE_VALID_S &
                           (pend_vec[RSA_S] | pend_vec[RSB_S] | pend_vec[RD_S] | clr_pend_hit);

    // Arbitration: load return, then hold entry, then a fresh ALU result.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
        wr_valid   = 1'b0;
        wr_rd      = 5'd0;
        wr_data    = 32'd0;
        wr_is_ld   = 1'b0;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        if (pop) begin
            wr_valid  = 1'b1;
            wr_rd     = tag_mem[rd_ptr];
            wr_data   = LD_RET_DATA_M;
            wr_is_ld  = 1'b1;
            hold_load = alu_accept;
        end else if (hold_full) begin
            wr_valid   = 1'b1;
            wr_rd      = hold_rd;
            wr_data    = hold_data;
            hold_clear = 1'b1;
        end else if (alu_accept) begin
            wr_valid = 1'b1;
            wr_rd    = ALU_RD_E;
            wr_data  = ALU_DATA_E;
        end
    end

    always_comb begin
        wr_dec = '0;
        pend_n = pend;
        for (int i = 1; i < 32; i++) begin
            wr_dec[i] = wr_valid & (wr_rd == 5'(i));
            if (wb_clr && wb_rd_q == 5'(i))
                pend_n[i] = 1'b0;
            // A set in the same cycle overrides the clear.
            if (push && LD_RD_E == 5'(i))
                pend_n[i] = 1'b1;
        end
    end

    // NOTE: the tag storage carries no reset; count and pointers alone define which entries are valid.
    always_ff @(posedge SYSCLK) begin
        if (push)
            tag_mem[wr_ptr] <= LD_RD_E;
    end

    always_ff @(posedge SYSCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (RESET_D1_R) begin
            pend       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            hold_full  <= 1'b0;
            hold_rd    <= 5'd0;
            hold_data  <= 32'd0;
            wb_ld_q    <= 1'b0;
            wb_rd_q    <= 5'd0;
            WRITEC_W_R <= '0;
            REGC_W_R   <= 32'd0;
        end else begin
            pend <= pend_n;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (hold_load) begin
                hold_full <= 1'b1;
                hold_rd   <= ALU_RD_E;
                hold_data <= ALU_DATA_E;
            end else if (hold_clear) begin
                hold_full <= 1'b0;
            end
            wb_ld_q    <= wr_is_ld;
            wb_rd_q    <= wr_rd;
            WRITEC_W_R <= wr_dec;
            if (wr_valid)
                REGC_W_R <= wr_data;
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctl.sv
// Self-checking bench for regfile_wb_ctl: encode table, directed hazard/arbitration
// sequences and randomized traffic against a queue-based reference model.
module tb_regfile_wb_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv;
    logic [4:0]  rsa, rsb, rds;
    logic        stall;
    logic [9:0]  reada, readb;
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ready;
    logic        ld;
    logic [4:0]  ld_rd;
    logic        full;
    logic        ret_v;
    logic [31:0] ret_data;
    logic [31:1] writec;
    logic [31:0] regc;

    always #5 clk = ~clk;

    regfile_wb_ctl #(.LDQ_DEPTH(4)) dut (
        .SYSCLK(clk), .RESET_D1_R(rst),
        .ISSUE_VALID_S(iv), .RSA_S(rsa), .RSB_S(rsb), .RD_S(rds),
        .ISSUE_STALL_S(stall), .READA_S(reada), .READB_S(readb),
        .ALU_VALID_E(alu_v), .ALU_RD_E(alu_rd), .ALU_DATA_E(alu_data), .ALU_READY_E(ready),
        .LD_ISSUE_E(ld), .LD_RD_E(ld_rd), .LD_FULL_E(full),
        .LD_RET_VALID_M(ret_v), .LD_RET_DATA_M(ret_data),
        .WRITEC_W_R(writec), .REGC_W_R(regc)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit [31:0]   m_pend;
    int          m_tags[$];
    bit          m_hold_v;
    int          m_hold_rd;
    logic [31:0] m_hold_data;
    int          m_last_ld;
    logic [31:0] m_wen;
    logic [31:0] m_wdata;
    bit          m_chk_data;

    function automatic void model_reset();
        m_pend = '0;
        m_tags.delete();
        m_hold_v = 0;
        m_hold_rd = 0;
        m_hold_data = '0;
        m_last_ld = -1;
        m_wen = '0;
        m_wdata = '0;
        m_chk_data = 1;
    endfunction

    function automatic logic [9:0] enc(input int r);
        return 10'(((r / 8) * 256) + (1 << (r % 8)));
    endfunction

    function automatic bit exp_stall();
        bit hit;
        hit = m_pend[rsa] | m_pend[rsb] | m_pend[rds];
        if (m_last_ld > 0 && (int'(rsa) == m_last_ld || int'(rsb) == m_last_ld || int'(rds) == m_last_ld))
            hit = 1;
        return iv & hit;
    endfunction

    function automatic void model_update();
        bit pop_now, push_now, accept, wrote;
        int rd;
        logic [31:0] data;
        if (rst) begin
            model_reset();
            return;
        end
        pop_now  = ret_v && m_tags.size() > 0;
        push_now = ld && m_tags.size() < 4;
        accept   = alu_v && !m_hold_v;
        if (m_last_ld > 0) m_pend[m_last_ld] = 0;
        if (push_now && ld_rd != 0) m_pend[ld_rd] = 1;
        wrote = 0; rd = 0; data = '0; m_last_ld = -1;
        if (pop_now) begin
            rd = m_tags.pop_front();
            data = ret_data;
            wrote = 1;
            m_last_ld = rd;
            if (accept) begin
                m_hold_v = 1; m_hold_rd = int'(alu_rd); m_hold_data = alu_data;
            end
        end else if (m_hold_v) begin
            rd = m_hold_rd; data = m_hold_data; wrote = 1; m_hold_v = 0;
        end else if (accept) begin
            rd = int'(alu_rd); data = alu_data; wrote = 1;
        end
        if (push_now) m_tags.push_back(int'(ld_rd));
        m_wen = (wrote && rd != 0) ? (32'd1 << rd) : 32'd0;
        if (wrote) m_wdata = data;
        m_chk_data = wrote;
    endfunction

    // One clock: check combinational outputs, clock, advance model, check registered outputs.
    task automatic tick();
        #1;
        check("stall", 32'(stall), 32'(exp_stall()));
        check("ready", 32'(ready), 32'(!m_hold_v));
        check("full", 32'(full), 32'(m_tags.size() == 4));
        check("reada", 32'(reada), 32'(enc(int'(rsa))));
        check("readb", 32'(readb), 32'(enc(int'(rsb))));
        @(posedge clk);
        model_update();
        #1;
        check("wen", {writec, 1'b0}, m_wen);
        if (m_chk_data) check("wdata", regc, m_wdata);
    endtask

    task automatic idle_inputs();
        rst = 0; iv = 0; rsa = 0; rsb = 0; rds = 0;
        alu_v = 0; alu_rd = 0; alu_data = 0;
        ld = 0; ld_rd = 0; ret_v = 0; ret_data = 0;
    endtask

    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        logic [9:0] exp_a;
        logic [9:0] exp_b;
    } enc_vec_t;

    enc_vec_t enc_tab[4];

    initial begin
        enc_tab[0] = '{5'd13, 5'd0,  10'h120, 10'h001};
        enc_tab[1] = '{5'd31, 5'd7,  10'h380, 10'h080};
        enc_tab[2] = '{5'd8,  5'd22, 10'h101, 10'h240};
        enc_tab[3] = '{5'd1,  5'd16, 10'h002, 10'h201};

        // Reset / encode
        idle_inputs();
        rst = 1;
        repeat (3) @(posedge clk);
        model_reset();
        #1;
        rst = 0;
        check("rst_writec", {writec, 1'b0}, 32'd0);
        check("rst_regc", regc, 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        iv = 1;
        for (int i = 0; i < 4; i++) begin
            rsa = enc_tab[i].a; rsb = enc_tab[i].b;
            #1;
            check("enc_a", 32'(reada), 32'(enc_tab[i].exp_a));
            check("enc_b", 32'(readb), 32'(enc_tab[i].exp_b));
            check("rst_stall", 32'(stall), 32'd0);
        end
        tick();

        // Load RAW stall
        idle_inputs();
        ld = 1; ld_rd = 5; iv = 1; rsa = 5; rsb = 0; rds = 10;
        #1; check("raw_c1_stall", 32'(stall), 32'd0);
        tick();
        ld = 0;
        #1; check("raw_c2_stall", 32'(stall), 32'd1);
        tick();
        #1; check("raw_c3_stall", 32'(stall), 32'd1);
        tick();
        ret_v = 1; ret_data = 32'hDEAD_BEEF;
        #1; check("raw_c4_stall", 32'(stall), 32'd1);
        tick();
        check("raw_c5_wen", {writec, 1'b0}, 32'h0000_0020);
        check("raw_c5_data", regc, 32'hDEAD_BEEF);
        ret_v = 0;
        #1; check("raw_c5_stall", 32'(stall), 32'd1);
        tick();
        #1; check("raw_c6_stall", 32'(stall), 32'd0);
        tick();

        // Collision: load return beats ALU, ALU drains from hold
        idle_inputs();
        ld = 1; ld_rd = 3;
        tick();
        ld = 0; alu_v = 1; alu_rd = 7; alu_data = 32'd1; ret_v = 1; ret_data = 32'd2;
        #1; check("col_n_ready", 32'(ready), 32'd1);
        tick();
        alu_v = 0; ret_v = 0;
        check("col_n1_wen", {writec, 1'b0}, 32'h0000_0008);
        check("col_n1_data", regc, 32'd2);
        #1; check("col_n1_ready", 32'(ready), 32'd0);
        tick();
        check("col_n2_wen", {writec, 1'b0}, 32'h0000_0080);
        check("col_n2_data", regc, 32'd1);
        #1; check("col_n2_ready", 32'(ready), 32'd1);
        tick();

        // Queue full
        idle_inputs();
        for (int i = 1; i <= 4; i++) begin
            ld = 1; ld_rd = 5'(i);
            tick();
        end
        ld = 1; ld_rd = 9;
        #1; check("q_full", 32'(full), 32'd1);
        tick();
        ld = 0; iv = 1; rsa = 9; rsb = 0; rds = 0;
        #1; check("q_no_pend9", 32'(stall), 32'd0);
        check("q_still_full", 32'(full), 32'd1);
        iv = 0;
        for (int i = 1; i <= 4; i++) begin
            ret_v = 1; ret_data = 32'(100 + i);
            tick();
            check("q_ret_wen", {writec, 1'b0}, 32'd1 << i);
            check("q_ret_data", regc, 32'(100 + i));
            if (i == 1) begin
                #1; check("q_full_fall", 32'(full), 32'd0);
            end
        end
        ret_v = 0;
        tick();

        // r0 write and return on empty FIFO
        idle_inputs();
        alu_v = 1; alu_rd = 0; alu_data = 32'd55;
        tick();
        check("r0_wen", {writec, 1'b0}, 32'd0);
        check("r0_data", regc, 32'd55);
        alu_v = 0; ret_v = 1; ret_data = 32'h1234_5678;
        tick();
        check("empty_ret_wen", {writec, 1'b0}, 32'd0);
        ret_v = 0;
        #1; check("empty_ret_full", 32'(full), 32'd0);
        check("empty_ret_ready", 32'(ready), 32'd1);
        tick();

        // Reset mid-flight: two loads pending and hold occupied
        idle_inputs();
        for (int i = 10; i <= 12; i++) begin
            ld = 1; ld_rd = 5'(i);
            tick();
        end
        ld = 0; ret_v = 1; ret_data = 32'd7; alu_v = 1; alu_rd = 20; alu_data = 32'd8;
        tick();
        ret_v = 0; alu_v = 0;
        #1; check("mf_hold_ready", 32'(ready), 32'd0);
        rst = 1;
        tick();
        rst = 0; iv = 1; rsa = 11; rsb = 12; rds = 10;
        check("mf_wen", {writec, 1'b0}, 32'd0);
        #1;
        check("mf_ready", 32'(ready), 32'd1);
        check("mf_full", 32'(full), 32'd0);
        check("mf_stall", 32'(stall), 32'd0);
        tick();
        check("mf_wen2", {writec, 1'b0}, 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            rst      = ($urandom_range(0, 99) == 0);
            iv       = $urandom_range(0, 1) == 1;
            rsa      = 5'($urandom_range(0, 7));
            rsb      = 5'($urandom_range(0, 31));
            rds      = 5'($urandom_range(0, 7));
            alu_v    = $urandom_range(0, 1) == 1;
            alu_rd   = 5'($urandom_range(0, 31));
            alu_data = $urandom;
            ld       = $urandom_range(0, 2) == 0;
            ld_rd    = 5'($urandom_range(0, 7));
            ret_v    = $urandom_range(0, 2) == 0;
            ret_data = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctl.md
# regfile_wb_ctl

Writeback and scoreboard stage that sits directly upstream of the register file. It merges ALU results and in-order load returns into a single registered one-hot write port (`WRITEC_W_R`/`REGC_W_R`). It tracks registers with outstanding loads and stalls issue on RAW/WAW hazards. It also encodes 5-bit source register numbers into the banked one-hot read selects the register file consumes.

## Interface
- `LDQ_DEPTH`, 4: outstanding-load tag FIFO depth (power of two).
- `SYSCLK` in 1: clock, all state on rising edge.
- `RESET_D1_R` in 1: reset, synchronous, active-high.
- `ISSUE_VALID_S` in 1: decode has an instruction presenting sources/dest.
- `RSA_S`, `RSB_S` in 5 each: source register numbers.
- `RD_S` in 5: destination register number of the issuing instruction.
- `ISSUE_STALL_S` out 1: hold the instruction in decode.
- `READA_S`, `READB_S` out 10 each: banked read selects for the register file.
- `ALU_VALID_E` in 1, `ALU_RD_E` in 5, `ALU_DATA_E` in 32: ALU result offer.
- `ALU_READY_E` out 1: ALU result accepted this cycle when high.
- `LD_ISSUE_E` in 1, `LD_RD_E` in 5: a load leaves execute and targets `LD_RD_E`.
- `LD_FULL_E` out 1: load tag FIFO full.
- `LD_RET_VALID_M` in 1, `LD_RET_DATA_M` in 32: load data return, in issue order.
- `WRITEC_W_R` out [31:1]: registered one-hot write enables.
- `REGC_W_R` out 32: registered write data.

## Operation
- **Read select encoding (combinational):** bits 9:8 = reg[4:3]; bits 7:0 = one-hot of reg[2:0]. r0 → 10'h001, r13 → 10'h120, r31 → 10'h380.
- **Scoreboard:** `pend[31:1]`; r0 is never pending.
  - `LD_ISSUE_E` with `!LD_FULL_E` and `LD_RD_E != 0` sets `pend[LD_RD_E]` and pushes `LD_RD_E` into the tag FIFO.
  - A load to r0 still pushes its tag, so returns stay aligned, but sets no pend bit.
- **Stall:** `ISSUE_STALL_S = ISSUE_VALID_S & (pend[RSA_S] | pend[RSB_S] | pend[RD_S] | clr_pend_hit)`.
  - `clr_pend_hit` covers the one cycle between a load writeback and the pend clear (see Timing).
  - With `ISSUE_VALID_S` low, `ISSUE_STALL_S` is 0.
- **Tag FIFO:**
  - Count ranges 0..`LDQ_DEPTH`; pointers wrap modulo depth.
  - `LD_FULL_E = (count == LDQ_DEPTH)`.
  - A push while full is ignored.
  - A return while empty is a protocol error: ignored, no write.
  - A simultaneous push and pop leaves the count unchanged.
- **Writeback arbitration, one write per cycle.** Priority order:
  1. load return (dest = FIFO head, pop);
  2. hold register;
  3. new ALU result.
- **Hold register:** one entry (rd, data).
  - Captures an accepted ALU result that loses arbitration.
  - `ALU_READY_E = !hold_full`.
  - `ALU_VALID_E` while not ready is ignored.
- **Writes to r0:** `WRITEC_W_R` = 0 and `REGC_W_R` is still updated. The slot is consumed and the FIFO pops normally.
- **Pend set/clear conflict:** if a set and a clear target the same register in the same cycle, set wins.

## Timing
- **Reset values:** `WRITEC_W_R` = 0, `REGC_W_R` = 0, `pend` = 0, FIFO empty, hold empty. Resulting outputs: `ALU_READY_E` = 1, `LD_FULL_E` = 0, `ISSUE_STALL_S` = 0.
- **Reset mid-operation:** discards all pending loads, the hold entry and any in-flight write. The write enable is 0 on the first cycle after reset.
- **Write latency:** a result accepted in cycle N appears on `WRITEC_W_R`/`REGC_W_R` in cycle N+1, held for exactly one cycle. The register file captures it at the end of N+1.
- **Pend clear:** `pend[rd]` for a load writeback clears at the end of cycle N+1, so a dependent issue un-stalls in N+2. This is the first cycle the register file output holds the new value.
  - `clr_pend_hit` is high in N+1 when `RSA_S`/`RSB_S`/`RD_S` matches the writing rd.
- **Hold drain:** an ALU result blocked in cycle N writes no earlier than N+2. `ALU_READY_E` is low from N+1 until the cycle after the hold drains.
- **Load flags:** `LD_FULL_E` rises the cycle after the 4th push and falls the cycle after a pop.

## Test plan
- **Reset/encode:** assert reset 3 cycles → all outputs at reset values. `RSA_S`=13, `RSB_S`=0 → `READA_S`=10'h120, `READB_S`=10'h001.
- **Load RAW stall:**
  - Stimulus: `LD_ISSUE_E` rd=5 in cycle 1; issue with `RSA_S`=5 held; return 32'hDEAD_BEEF in cycle 4.
  - Response: `WRITEC_W_R`=1<<5 and data DEAD_BEEF in cycle 5; `ISSUE_STALL_S` high through cycle 5, low in cycle 6.
- **Collision:**
  - Stimulus: ALU rd=7 data 1 and load return rd=3 data 2 in the same cycle N.
  - Response: rd3 written in N+1, rd7 in N+2; `ALU_READY_E` low in N+1 only.
- **Queue full:**
  - Stimulus: 4 loads rd=1..4, then a 5th load rd=9.
  - Response: `LD_FULL_E`=1 and the 5th is ignored (`pend[9]` stays 0). Returns write rd 1,2,3,4 in order.
- **r0/protocol:**
  - ALU write to r0 → `WRITEC_W_R`=0.
  - Return with empty FIFO → no write, state unchanged.
- **Reset mid-flight:** 2 loads pending and hold full, then reset → `pend`=0, `LD_FULL_E`=0, `ALU_READY_E`=1, no write after reset.
